// File: rtl/prog_delay_line.sv
// Programmable multi-channel delay line with run-time tap selection.
// A delay change flushes the shared valid chain and refills before data is trusted again.
module prog_delay_line #(
  parameter int MAX_DELAY  = 16,
  parameter int INIT_DELAY = 1,
  parameter int BITWIDTH   = 8,
  parameter int CHANNELS   = 1,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic [DW-1:0]                dly_sel,
  input  logic                         dly_load,
  input  logic                         i_valid,
  input  logic [BITWIDTH*CHANNELS-1:0] i,
  output logic                         o_valid,
  output logic [BITWIDTH*CHANNELS-1:0] o,
  output logic [DW-1:0]                dly_cur,
  output logic                         busy
);

  localparam int W = BITWIDTH * CHANNELS;
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DELAY);
  localparam logic [DW-1:0] INIT_D = DW'(INIT_DELAY);
  localparam logic [DW-1:0] ONES   = {DW{1'b1}};

  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   cnt_inc;
  logic [DW-1:0]   dly_clamp;
  logic [W-1:0]    stage [MAX_DELAY];
  logic [MAX_DELAY-1:0] vbit;
  logic [W-1:0]    tap_data;
  logic            tap_valid;

  // Clamp the requested delay and form the saturating refill increment.
  always_comb begin
    dly_clamp = dly_sel;
    cnt_inc   = cnt;
    if (dly_sel > MAX_D) begin
      dly_clamp = MAX_D;
    end else begin
      dly_clamp = dly_sel;
    end
    if (cnt == ONES) begin
      cnt_inc = cnt;
    end else begin
      cnt_inc = cnt + DW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (INIT_DELAY > 0) ? REFILL : RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a fresh load always overrides the current refill.
  always_comb begin
    state_next = state;
    if (dly_load) begin
      if (dly_clamp != '0) begin
        state_next = REFILL;
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state)
        RUN:     state_next = RUN;
        REFILL: begin
          if (ce && (cnt_inc == dly_cur)) begin
            state_next = RUN;
          end else begin
            state_next = REFILL;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Output decode of the FSM.
  always_comb begin
    busy = 1'b0;
    case (state)
      RUN:     busy = 1'b0;
      REFILL:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Delay setting and refill counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_cur <= INIT_D;
      cnt     <= '0;
    end else if (dly_load) begin
      dly_cur <= dly_clamp;
      cnt     <= '0;
    end else if ((state == REFILL) && ce) begin
      cnt <= cnt_inc;
    end
  end

  // Data stages shift on ce; the flush clears only the valid chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        stage[k] <= '0;
      end
      vbit <= '0;
    end else begin
      if (ce) begin
        stage[0] <= i;
        for (int k = 1; k < MAX_DELAY; k++) begin
          stage[k] <= stage[k-1];
        end
      end
      if (dly_load) begin
        vbit <= '0;
        if (ce) begin
          vbit[0] <= i_valid;
        end
      end else if (ce) begin
        vbit[0] <= i_valid;
        for (int k = 1; k < MAX_DELAY; k++) begin
          vbit[k] <= vbit[k-1];
        end
      end
    end
  end

  // Tap select; a zero delay is a straight combinational bypass.
  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (dly_cur == DW'(k + 1)) begin
        tap_data  = stage[k];
        tap_valid = vbit[k];
      end
    end
    if (dly_cur == '0) begin
      o       = i;
      o_valid = i_valid;
    end else begin
      o       = tap_data;
      o_valid = tap_valid;
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line: a default 8-bit instance and
// a 3x12-bit instance sharing the same control, driven with ramps.
module tb_prog_delay_line;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [4:0]  dly_sel;
  logic        dly_load;
  logic        i_valid;
  logic [7:0]  i;
  logic        o_valid;
  logic [7:0]  o;
  logic [4:0]  dly_cur;
  logic        busy;
  logic [35:0] i2;
  logic        o_valid2;
  logic [35:0] o2;
  logic [4:0]  dly_cur2;
  logic        busy2;

  int compared   = 0;
  int mismatched = 0;
  int n;
  int n0;

  always #5 clk = ~clk;

  prog_delay_line dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dly_sel(dly_sel), .dly_load(dly_load),
    .i_valid(i_valid), .i(i), .o_valid(o_valid), .o(o), .dly_cur(dly_cur), .busy(busy)
  );

  prog_delay_line #(.MAX_DELAY(16), .INIT_DELAY(1), .BITWIDTH(12), .CHANNELS(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dly_sel(dly_sel), .dly_load(dly_load),
    .i_valid(i_valid), .i(i2), .o_valid(o_valid2), .o(o2), .dly_cur(dly_cur2), .busy(busy2)
  );

  // Distinct per-channel patterns so any cross-channel bit leakage shows up.
  function automatic logic [35:0] pat(input logic [7:0] v);
    logic [11:0] a;
    a = {4'h0, v};
    return {a ^ 12'hA5A, ~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    i  = v;
    i2 = pat(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; dly_load = 1'b0; dly_sel = 5'd0; i_valid = 1'b0;
    drive(8'hAA);
    repeat (3) tick;
    chk("rst_o", o, 64'd0);
    chk("rst_ov", o_valid, 64'd0);
    chk("rst_dly", dly_cur, 64'd1);
    chk("rst_busy", busy, 64'd1);
    chk("rst_o2", o2, 64'd0);

    // D=1 ramp after reset
    rst_n = 1'b1; i_valid = 1'b1; n = 1;
    for (int k = 0; k < 4; k++) begin
      drive(8'(n)); tick;
      chk("d1_o", o, 64'(n));
      chk("d1_ov", o_valid, 64'd1);
      chk("d1_busy", busy, 64'd0);
      n++;
    end
    drive(8'h77); #1;
    chk("d1_nocomb", o, 64'(n - 1));

    // reload of the same delay still flushes/refills
    dly_sel = 5'd1; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    chk("same_busy", busy, 64'd1);
    chk("same_dly", dly_cur, 64'd1);
    drive(8'(n)); tick;
    chk("same_busy2", busy, 64'd0);
    chk("same_o", o, 64'(n));
    n++;

    // load 5 mid-stream
    dly_sel = 5'd5; dly_load = 1'b1; drive(8'(n)); n0 = n; tick; dly_load = 1'b0; n++;
    chk("d5_dly", dly_cur, 64'd5);
    chk("d5_busy0", busy, 64'd1);
    chk("d5_ov0", o_valid, 64'd0);
    for (int j = 1; j <= 7; j++) begin
      drive(8'(n)); tick;
      if (j <= 3) begin
        chk("d5_ov_fill", o_valid, 64'd0);
        chk("d5_busy_fill", busy, 64'd1);
      end
      if (j == 4) begin
        chk("d5_first", o, 64'(n0));
        chk("d5_busy4", busy, 64'd1);
      end
      if (j >= 5) begin
        chk("d5_o", o, 64'(n - 4));
        chk("d5_ov", o_valid, 64'd1);
        chk("d5_busy", busy, 64'd0);
      end
      n++;
    end

    // D=3 with ce toggling; junk presented while ce=0 must never be captured
    dly_sel = 5'd3; dly_load = 1'b1; drive(8'(n)); n0 = n; tick; dly_load = 1'b0; n++;
    ce = 1'b0; drive(8'hEE); tick;
    chk("ce_ov_e1", o_valid, 64'd0);
    chk("ce_busy_e1", busy, 64'd1);
    ce = 1'b1; drive(8'(n)); tick; n++;
    ce = 1'b0; drive(8'hEE); tick;
    chk("ce_ov_e3", o_valid, 64'd0);
    ce = 1'b1; drive(8'(n)); tick; n++;
    chk("ce_o_e4", o, 64'(n0));
    chk("ce_ov_e4", o_valid, 64'd1);
    ce = 1'b0; drive(8'hEE); tick;
    chk("ce_hold_e5", o, 64'(n0));
    chk("ce_busy_e5", busy, 64'd1);
    ce = 1'b1; drive(8'(n)); tick; n++;
    chk("ce_o_e6", o, 64'(n0 + 1));
    chk("ce_busy_e6", busy, 64'd0);

    // clamp above MAX_DELAY, then zero delay bypass
    dly_sel = 5'd20; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    chk("clamp_dly", dly_cur, 64'd16);
    chk("clamp_busy", busy, 64'd1);
    dly_sel = 5'd0; dly_load = 1'b1; tick; dly_load = 1'b0;
    chk("d0_busy", busy, 64'd0);
    chk("d0_dly", dly_cur, 64'd0);
    drive(8'h5A); i_valid = 1'b1; #1;
    chk("d0_o", o, 64'h5A);
    chk("d0_o2", o2, 64'(pat(8'h5A)));
    chk("d0_ov1", o_valid, 64'd1);
    i_valid = 1'b0; #1;
    chk("d0_ov0", o_valid, 64'd0);
    ce = 1'b0; drive(8'h33); #1;
    chk("d0_noce", o, 64'h33);
    ce = 1'b1; i_valid = 1'b1;

    // load 8, then load 2 mid-refill
    dly_sel = 5'd8; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    chk("r8_dly", dly_cur, 64'd8);
    repeat (3) begin drive(8'(n)); tick; n++; end
    chk("r8_busy", busy, 64'd1);
    dly_sel = 5'd2; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    chk("r2_dly", dly_cur, 64'd2);
    chk("r2_busy0", busy, 64'd1);
    drive(8'(n)); tick; n++;
    chk("r2_busy1", busy, 64'd1);
    drive(8'(n)); tick; n++;
    chk("r2_busy2", busy, 64'd0);
    chk("r2_o", o, 64'(n - 2));
    chk("r2_ov", o_valid, 64'd1);

    // reset mid-refill, then reset together with a load
    dly_sel = 5'd8; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    drive(8'(n)); tick; n++;
    chk("mr_busy", busy, 64'd1);
    rst_n = 1'b0; tick;
    chk("mr_dly", dly_cur, 64'd1);
    chk("mr_ov", o_valid, 64'd0);
    chk("mr_o", o, 64'd0);
    chk("mr_busy_rst", busy, 64'd1);
    dly_sel = 5'd6; dly_load = 1'b1; tick; dly_load = 1'b0;
    chk("rl_dly", dly_cur, 64'd1);
    rst_n = 1'b1;

    // wide instance at D=4
    dly_sel = 5'd4; dly_load = 1'b1; drive(8'(n)); tick; dly_load = 1'b0; n++;
    chk("w_dly", dly_cur2, 64'd4);
    for (int j = 1; j <= 7; j++) begin
      drive(8'(n)); tick;
      if (j >= 4) begin
        chk("w_o2", o2, 64'(pat(8'(n - 3))));
        chk("w_ov2", o_valid2, 64'd1);
        chk("w_o", o, 64'(n - 3));
      end
      n++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
